// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} pairs
// with valid/ready on both sides, one-cycle flush and optional bypass.
//
// Ports:
//   CLK, nRST               clock (rising edge), async active-low reset
//   flush                   discard all buffered entries at the next edge
//   in_valid/in_ready       fetch-side handshake, carrying in_pc/in_inst
//   out_valid/out_ready     decode-side handshake, carrying out_pc/out_inst
//   count/full/empty        occupancy status
module fetch_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int BYPASS = 0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            thru;
  logic            wr_en;
  logic            rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // in_ready deliberately ignores out_ready: no comb path decode->fetch.
  assign in_ready = !full && !flush;

  always_comb begin
    head      = mem[rd_ptr];
    out_valid = !empty;
    out_pc    = head.pc;
    out_inst  = head.inst;
    if (BYPASS != 0 && empty) begin
      out_valid = in_valid;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
    if (flush) begin
      out_valid = 1'b0;
    end
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Bypassed entry consumed in the same cycle never touches storage.
  assign thru  = (BYPASS != 0) && empty && push && pop;
  assign wr_en = push && !thru;
  assign rd_en = pop && !thru;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        (wr_en && !rd_en): cnt <= cnt + CW'(1);
        (rd_en && !wr_en): cnt <= cnt - CW'(1);
        default:           cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge CLK) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized + directed bench for fetch_decode_queue, BYPASS=0 and
// BYPASS=1 instances checked against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;

  int checks;
  int failures;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;

  logic        ir_a, ov_a, fu_a, em_a;
  logic [31:0] opc_a, oin_a;
  logic [2:0]  cnt_a;
  logic        ir_b, ov_b, fu_b, em_b;
  logic [31:0] opc_b, oin_b;
  logic [2:0]  cnt_b;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [31:0] pc_gen;

  always #5 CLK = ~CLK;

  fetch_decode_queue #(.DEPTH(DEPTH), .WORD_W(32), .BYPASS(0)) dut_a (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_pc(opc_a), .out_inst(oin_a),
    .count(cnt_a), .full(fu_a), .empty(em_a)
  );

  fetch_decode_queue #(.DEPTH(DEPTH), .WORD_W(32), .BYPASS(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_b),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_pc(opc_b), .out_inst(oin_b),
    .count(cnt_b), .full(fu_b), .empty(em_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit byp, input logic ir, input logic ov,
                       input logic [31:0] opc, input logic [31:0] oin,
                       input logic [2:0] cnt, input logic fu,
                       input logic em);
    logic [63:0] q[$];
    logic [63:0] hd;
    logic        e_ir;
    logic        e_ov;
    int          n;
    string       s;
    q = byp ? qb : qa;
    s = byp ? "b" : "a";
    n = q.size();
    e_ir = !flush && (n < DEPTH);
    if (flush)      e_ov = 1'b0;
    else if (n > 0) e_ov = 1'b1;
    else            e_ov = byp ? in_valid : 1'b0;
    chk({s, ".count"}, 64'(cnt), 64'(n));
    chk({s, ".full"}, 64'(fu), 64'(n == DEPTH));
    chk({s, ".empty"}, 64'(em), 64'(n == 0));
    chk({s, ".in_ready"}, 64'(ir), 64'(e_ir));
    chk({s, ".out_valid"}, 64'(ov), 64'(e_ov));
    if (e_ov) begin
      hd = (n > 0) ? q[0] : {in_pc, in_inst};
      chk({s, ".out_pc"}, 64'(opc), 64'(hd[63:32]));
      chk({s, ".out_inst"}, 64'(oin), 64'(hd[31:0]));
    end
    if (flush) begin
      q.delete();
    end else begin
      if (in_valid && e_ir) q.push_back({in_pc, in_inst});
      if (e_ov && out_ready) void'(q.pop_front());
    end
    if (byp) qb = q;
    else     qa = q;
  endtask

  task automatic cyc(input logic fl, input logic iv, input logic orr,
                     input logic [31:0] pc);
    @(negedge CLK);
    flush     = fl;
    in_valid  = iv;
    out_ready = orr;
    in_pc     = pc;
    in_inst   = $urandom;
    #1;
    model(1'b0, ir_a, ov_a, opc_a, oin_a, cnt_a, fu_a, em_a);
    model(1'b1, ir_b, ov_b, opc_b, oin_b, cnt_b, fu_b, em_b);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    nRST      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    pc_gen    = 32'h1000;

    // Reset state
    #12;
    chk("rst.a.out_valid", 64'(ov_a), 64'd0);
    chk("rst.a.in_ready", 64'(ir_a), 64'd1);
    chk("rst.a.empty", 64'(em_a), 64'd1);
    chk("rst.a.full", 64'(fu_a), 64'd0);
    chk("rst.a.count", 64'(cnt_a), 64'd0);
    chk("rst.b.out_valid", 64'(ov_b), 64'd0);
    chk("rst.b.count", 64'(cnt_b), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // 1: single push, visible next cycle
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h100; in_inst = 32'h00000013;
    #1;
    model(1'b0, ir_a, ov_a, opc_a, oin_a, cnt_a, fu_a, em_a);
    model(1'b1, ir_b, ov_b, opc_b, oin_b, cnt_b, fu_b, em_b);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1.a.out_pc", 64'(opc_a), 64'h100);
    chk("t1.a.count", 64'(cnt_a), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // 2: fill to full, 5th push ignored, drain in order
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'(i * 4));
    chk("t2.a.full", 64'(fu_a), 64'd1);
    chk("t2.a.in_ready", 64'(ir_a), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0);

    // 3: steady push&pop at count=2
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h300);
    cyc(1'b0, 1'b1, 1'b0, 32'h304);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 32'(32'h308 + i * 4));

    // 4: flush at count=3 with traffic on both sides
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'(32'h400 + i * 4));
    cyc(1'b1, 1'b1, 1'b1, 32'h40c);
    chk("t4.a.out_valid", 64'(ov_a), 64'd0);
    chk("t4.b.in_ready", 64'(ir_b), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // 5: bypass on empty queue
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    chk("t5.b.out_pc", 64'(opc_b), 64'h200);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5.b.count", 64'(cnt_b), 64'd0);

    // 6: async reset mid-cycle at count=2
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h500);
    cyc(1'b0, 1'b1, 1'b0, 32'h504);
    @(negedge CLK);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("t6.a.pre_count", 64'(cnt_a), 64'd2);
    #1 nRST = 1'b0;
    #1;
    chk("t6.a.out_valid", 64'(ov_a), 64'd0);
    chk("t6.a.count", 64'(cnt_a), 64'd0);
    chk("t6.b.out_valid", 64'(ov_b), 64'd0);
    chk("t6.b.count", 64'(cnt_b), 64'd0);
    qa.delete();
    qb.delete();
    @(negedge CLK);
    nRST = 1'b1;

    // Random traffic with phase-varying decode pressure
    for (int i = 0; i < 600; i++) begin
      logic fl, iv, orr;
      int   ph;
      ph  = (i / 100) % 4;
      fl  = ($urandom_range(0, 29) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 3) < ph) || (ph == 0 && $urandom_range(0, 1) == 0);
      cyc(fl, iv, orr, pc_gen);
      pc_gen = pc_gen + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
